// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage. It decodes the opcode into ALU and memory
// controls, splits out the register fields and sign-extends the immediate. The
// result is held in an output register behind a valid/ready handshake. A load
// followed by a dependent instruction gets a one-cycle bubble, and flush kills
// the held and the incoming instruction.
module decode_stage #(
  parameter int unsigned INSTR_W   = 16,
  parameter int unsigned REG_AW    = 3,
  parameter int unsigned JUMP_MODE = 0,
  parameter int unsigned HAZARD_EN = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] in_instr_i,
  input  logic               flush_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2:0]         out_alu_op_o,
  output logic               out_reg_write_o,
  output logic               out_mem_read_o,
  output logic               out_mem_write_o,
  output logic               out_branch_o,
  output logic               out_jump_o,
  output logic [REG_AW-1:0]  out_rd_o,
  output logic [REG_AW-1:0]  out_rs_o,
  output logic [REG_AW-1:0]  out_rt_o,
  output logic [INSTR_W-1:0] out_imm_o,
  output logic [15:0]        hazard_cnt_o
);

  // Whatever is left below opcode and the three register fields is the immediate.
  localparam int unsigned ImmW = INSTR_W - 3 - 3 * REG_AW;
  localparam int unsigned ExtW = INSTR_W - ImmW;

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpAddi = 3'b001,
    OpSub  = 3'b010,
    OpSubi = 3'b011,
    OpLui  = 3'b100,
    OpBeq  = 3'b101,
    OpSw   = 3'b110,
    OpLw   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluOr  = 3'b011
  } alu_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // Field extraction, MSB first.
  op_e               opcode;
  logic [REG_AW-1:0] rd_field;
  logic [REG_AW-1:0] rs_field;
  logic [REG_AW-1:0] rt_field;
  logic [ImmW-1:0]   imm_field;
  logic [INSTR_W-1:0] imm_ext;

  assign opcode    = op_e'(in_instr_i[INSTR_W-1 -: 3]);
  assign rd_field  = in_instr_i[INSTR_W-4 -: REG_AW];
  assign rs_field  = in_instr_i[INSTR_W-4-REG_AW -: REG_AW];
  assign rt_field  = in_instr_i[INSTR_W-4-2*REG_AW -: REG_AW];
  assign imm_field = in_instr_i[ImmW-1:0];
  assign imm_ext   = {{ExtW{imm_field[ImmW-1]}}, imm_field};

  ctrl_t ctrl_dec;
  logic  uses_rs;
  logic  uses_rt;

  // Opcode decode: control strobes plus which source registers are read.
  always_comb begin
    ctrl_dec = '0;
    uses_rs  = 1'b1;
    uses_rt  = 1'b0;
    unique case (opcode)
      OpAdd: begin
        ctrl_dec.alu_op    = AluAdd;
        ctrl_dec.reg_write = 1'b1;
        uses_rt            = 1'b1;
      end
      OpAddi: begin
        ctrl_dec.alu_op    = AluAdd;
        ctrl_dec.reg_write = 1'b1;
      end
      OpSub: begin
        ctrl_dec.alu_op    = AluSub;
        ctrl_dec.reg_write = 1'b1;
        uses_rt            = 1'b1;
      end
      OpSubi: begin
        ctrl_dec.alu_op    = AluSub;
        ctrl_dec.reg_write = 1'b1;
      end
      OpLui: begin
        uses_rs = 1'b0;
        if (JUMP_MODE != 0) begin
          ctrl_dec.alu_op = AluAdd;
          ctrl_dec.jump   = 1'b1;
        end else begin
          ctrl_dec.alu_op    = AluOr;
          ctrl_dec.reg_write = 1'b1;
        end
      end
      OpBeq: begin
        ctrl_dec.alu_op = AluSub;
        ctrl_dec.branch = 1'b1;
        uses_rt         = 1'b1;
      end
      OpSw: begin
        ctrl_dec.mem_write = 1'b1;
        uses_rt            = 1'b1;
      end
      OpLw: begin
        ctrl_dec.mem_read  = 1'b1;
        ctrl_dec.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Output register state.
  logic               out_valid_q, out_valid_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic [REG_AW-1:0]  rd_q, rd_d;
  logic [REG_AW-1:0]  rs_q, rs_d;
  logic [REG_AW-1:0]  rt_q, rt_d;
  logic [INSTR_W-1:0] imm_q, imm_d;
  logic [15:0]        hazard_cnt_q, hazard_cnt_d;

  logic hazard;
  logic in_ready;
  logic accept;
  logic bubble;

  // Load-use interlock against the load currently held in the output register.
  always_comb begin
    hazard = 1'b0;
    if ((HAZARD_EN != 0) && in_valid_i && out_valid_q && ctrl_q.mem_read) begin
      hazard = (uses_rs && (rs_field == rd_q)) || (uses_rt && (rt_field == rd_q));
    end
  end

  assign in_ready = !rst_i && !flush_i && !hazard && (!out_valid_q || out_ready_i);
  assign accept   = in_valid_i && in_ready;
  // The load leaves while the dependent instruction is held off: that is one bubble.
  assign bubble   = hazard && out_ready_i && !flush_i;

  // Next-state for the output register and the bubble counter.
  always_comb begin
    out_valid_d  = out_valid_q;
    ctrl_d       = ctrl_q;
    rd_d         = rd_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    imm_d        = imm_q;
    hazard_cnt_d = hazard_cnt_q;

    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      ctrl_d      = ctrl_dec;
      rd_d        = rd_field;
      rs_d        = rs_field;
      rt_d        = rt_field;
      imm_d       = imm_ext;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (bubble && (hazard_cnt_q != 16'hFFFF)) begin
      hazard_cnt_d = hazard_cnt_q + 16'd1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      ctrl_q       <= '0;
      rd_q         <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      imm_q        <= '0;
      hazard_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      ctrl_q       <= ctrl_d;
      rd_q         <= rd_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      imm_q        <= imm_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign in_ready_o      = in_ready;
  assign out_valid_o     = out_valid_q;
  assign out_alu_op_o    = ctrl_q.alu_op;
  assign out_reg_write_o = ctrl_q.reg_write;
  assign out_mem_read_o  = ctrl_q.mem_read;
  assign out_mem_write_o = ctrl_q.mem_write;
  assign out_branch_o    = ctrl_q.branch;
  assign out_jump_o      = ctrl_q.jump;
  assign out_rd_o        = rd_q;
  assign out_rs_o        = rs_q;
  assign out_rt_o        = rt_q;
  assign out_imm_o       = imm_q;
  assign hazard_cnt_o    = hazard_cnt_q;

endmodule
